// File: rtl/multicycle_control_unit_pkg.sv
// cu_pkg: shared state, opcode, ALU, ImmSrc and Resultsrc encodings for the multicycle control unit.
// CU_TRAP_EN adds the TRAP state and redirects illegal instructions to it.
package cu_pkg;
`ifdef CU_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_e;
    localparam state_e S_ILLEGAL = S_TRAP;
`else
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
    } state_e;
    localparam state_e S_ILLEGAL = S_FETCH;
`endif
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} aluop_e;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;
    // funct3[2] picks signed/unsigned compare vs equality; funct3[0] inverts the condition
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt,
                                          input logic ltu);
        return f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (!f3[1] && (z ^ f3[0]));
    endfunction
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction/flag inputs and datapath control outputs of the control unit.
// illegal_o exists only when CU_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4,
    parameter int IMM_WIDTH     = 3
);
    logic [DATA_WIDTH-1:0]    instr_i;
    logic                     mem_ready_i;
    logic                     Zero_i;
    logic                     LessThan_i;
    logic                     LessThanU_i;
    logic                     PCWrite_o;
    logic                     AdrSrc_o;
    logic                     IRWrite_o;
    logic                     MemRead_o;
    logic                     MemWrite_o;
    logic [1:0]               MemSize_o;
    logic                     MemSign_o;
    logic                     RegWrite_o;
    logic [1:0]               ALUSrcA_o;
    logic [1:0]               ALUSrcB_o;
    logic [CONTROL_WIDTH-1:0] ALUctrl_o;
    logic [IMM_WIDTH-1:0]     ImmSrc_o;
    logic [1:0]               Resultsrc_o;
    logic [3:0]               state_o;
`ifdef CU_TRAP_EN
    logic                     illegal_o;
`endif
    modport master (
        input  instr_i, mem_ready_i, Zero_i, LessThan_i, LessThanU_i,
        output PCWrite_o, AdrSrc_o, IRWrite_o, MemRead_o, MemWrite_o, MemSize_o, MemSign_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUctrl_o, ImmSrc_o, Resultsrc_o, state_o
`ifdef CU_TRAP_EN
        , output illegal_o
`endif
    );
    modport slave (
        output instr_i, mem_ready_i, Zero_i, LessThan_i, LessThanU_i,
        input  PCWrite_o, AdrSrc_o, IRWrite_o, MemRead_o, MemWrite_o, MemSize_o, MemSign_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUctrl_o, ImmSrc_o, Resultsrc_o, state_o
`ifdef CU_TRAP_EN
        , input illegal_o
`endif
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: maps ALUOp class plus funct3/funct7[5] to the ALU control code.
module alu_decoder
    import cu_pkg::*;
#(
    parameter int CONTROL_WIDTH = 4
) (
    input  aluop_e                   aluop_i,
    input  logic [2:0]               funct3_i,
    input  logic                     funct7_5_i,
    input  logic                     op5_i,
    output logic [CONTROL_WIDTH-1:0] ALUctrl_o
);
    logic [3:0] funct_op;
    always_comb begin
        funct_op = ALU_ADD;
        case (funct3_i)
            3'b000: funct_op = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b001: funct_op = ALU_SLL;
            3'b010: funct_op = ALU_SLT;
            3'b011: funct_op = ALU_SLTU;
            3'b100: funct_op = ALU_XOR;
            3'b101: funct_op = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110: funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
    end
    assign ALUctrl_o = CONTROL_WIDTH'(aluop_i == AOP_FUNCT ? funct_op :
                                      aluop_i == AOP_SUB ? ALU_SUB : ALU_ADD);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle control FSM driving the shared-datapath controls.
// Define CU_TRAP_EN for an absorbing TRAP state and illegal_o on unknown instructions.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4,
    parameter int IMM_WIDTH     = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    multicycle_control_unit_if.master bus
);
    state_e                   state_q, state_d;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     funct7_5;
    logic                     unused_instr;
    logic                     pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, mem_access;
    logic [1:0]               src_a, src_b, result_src;
    logic [2:0]               imm_src;
    aluop_e                   alu_op;
    logic [CONTROL_WIDTH-1:0] alu_ctrl;
    assign opcode       = bus.instr_i[6:0];
    assign funct3       = bus.instr_i[14:12];
    assign funct7_5     = bus.instr_i[30];
    assign unused_instr = ^{bus.instr_i[DATA_WIDTH-1:31], bus.instr_i[29:15], bus.instr_i[11:7]};
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = bus.mem_ready_i ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = bus.mem_ready_i ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_BRANCH:   state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_FETCH;
`ifdef CU_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= S_FETCH;
        else state_q <= state_d;
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_access = 1'b0;
        src_a      = A_PC;
        src_b      = B_RS2;
        alu_op     = AOP_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = B_FOUR;
                ir_write = bus.mem_ready_i;
                pc_write = bus.mem_ready_i;
            end
            S_DECODE: begin
                src_a   = A_OLDPC;
                src_b   = B_IMM;
                imm_src = IMM_B;
            end
            S_MEMADR: begin
                src_a   = A_RS1;
                src_b   = B_IMM;
                imm_src = opcode[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_read   = 1'b1;
                adr_src    = 1'b1;
                mem_access = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                mem_access = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                mem_access = 1'b1;
            end
            S_EXECR: begin
                src_a  = A_RS1;
                alu_op = AOP_FUNCT;
            end
            S_EXECI: begin
                src_a  = A_RS1;
                src_b  = B_IMM;
                alu_op = AOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                src_a    = A_RS1;
                alu_op   = AOP_SUB;
                pc_write = branch_taken(funct3, bus.Zero_i, bus.LessThan_i, bus.LessThanU_i);
            end
            S_JAL, S_JALR: begin
                src_a      = A_OLDPC;
                src_b      = B_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                imm_src    = (state_q == S_JAL) ? IMM_J : IMM_I;
            end
            S_LUI, S_AUIPC: begin
                src_a      = (state_q == S_LUI) ? A_ZERO : A_OLDPC;
                src_b      = B_IMM;
                imm_src    = IMM_U;
                result_src = RES_ALU;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
    end
    alu_decoder #(.CONTROL_WIDTH(CONTROL_WIDTH)) u_alu_decoder (
        .aluop_i   (alu_op),
        .funct3_i  (funct3),
        .funct7_5_i(funct7_5),
        .op5_i     (opcode[5]),
        .ALUctrl_o (alu_ctrl)
    );
    // Reset masks every output combinationally so an aborted instruction writes nothing
    assign bus.PCWrite_o   = !rst_i && pc_write;
    assign bus.AdrSrc_o    = !rst_i && adr_src;
    assign bus.IRWrite_o   = !rst_i && ir_write;
    assign bus.MemRead_o   = !rst_i && mem_read;
    assign bus.MemWrite_o  = !rst_i && mem_write;
    assign bus.RegWrite_o  = !rst_i && reg_write;
    assign bus.MemSize_o   = (!rst_i && mem_access) ? funct3[1:0] : 2'b00;
    assign bus.MemSign_o   = !rst_i && mem_access && !funct3[2];
    assign bus.ALUSrcA_o   = rst_i ? 2'b00 : src_a;
    assign bus.ALUSrcB_o   = rst_i ? 2'b00 : src_b;
    assign bus.ALUctrl_o   = rst_i ? '0 : alu_ctrl;
    assign bus.ImmSrc_o    = rst_i ? '0 : IMM_WIDTH'(imm_src);
    assign bus.Resultsrc_o = rst_i ? 2'b00 : result_src;
    assign bus.state_o     = state_q;
`ifdef CU_TRAP_EN
    assign bus.illegal_o   = !rst_i && (state_q == S_TRAP);
`endif
endmodule
